// File: rtl/maxpool2d_2x2_stride2_16_to_8_64ch.sv
// 2x2 / stride-2 unsigned max pooling of a 16x16x64 nibble feature map into 8x8x64.
// Pooled nibbles are packed one output row per 32-bit buffer word; the consumer read port is always live.
`timescale 1ns/1ps

module maxpool2d_2x2_stride2_16_to_8_64ch #(
  parameter int IN_W  = 16,
  parameter int IN_H  = 16,
  parameter int CH    = 64,
  parameter int OUT_W = IN_W / 2,
  parameter int OUT_H = IN_H / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        up_start,
  input  logic        up_done,
  output logic [31:0] up_read_addr,
  input  logic [3:0]  up_read_data,
  input  logic [31:0] read_addr,
  output logic [3:0]  read_data,
  output logic        done
);

  localparam int CH_W   = $clog2(CH);
  localparam int ROW_W  = $clog2(OUT_H);
  localparam int COL_W  = $clog2(OUT_W);
  localparam int WORDS  = CH * OUT_H;
  localparam int WORD_W = $clog2(WORDS);
  localparam int PACK_W = 4 * OUT_W;

  typedef enum logic [3:0] {
    IDLE, START_UP, WAIT_UP, RD0, RD1, RD2, RD3, CMP, DONE_ST
  } state_t;

  state_t r_state, w_next;

  logic [CH_W-1:0]   r_ch, w_chNext;
  logic [ROW_W-1:0]  r_orow, w_orowNext;
  logic [COL_W-1:0]  r_ocol, w_ocolNext;
  logic [PACK_W-1:0] r_pack, w_packed;
  logic [3:0]        r_max, w_pixMax;
  logic [31:0]       r_upAddr;
  logic              r_upStart, r_done;
  logic [3:0]        r_readData;
  logic              w_lastCol, w_lastRow, w_lastCh, w_lastPix;
  logic              w_wrEn;
  logic [WORD_W-1:0] w_wrIdx, w_rdWord;
  logic [COL_W-1:0]  w_rdCol;
  logic [PACK_W-1:0] w_rdWordData;
  logic [3:0]        w_rdNib;
  logic              w_unusedAddrBits;

  logic [PACK_W-1:0] r_mem [WORDS];

  function automatic logic [31:0] pixAddr(input logic [CH_W-1:0] ch, input logic [ROW_W-1:0] orow,
                                          input logic [COL_W-1:0] ocol, input logic dr, input logic dc);
    logic [31:0] row;
    logic [31:0] col;
    row = (32'(orow) << 1) | 32'(dr);
    col = (32'(ocol) << 1) | 32'(dc);
    return 32'(ch) * 32'(IN_W * IN_H) + row * 32'(IN_W) + col;
  endfunction

  assign w_lastCol = (r_ocol == COL_W'(OUT_W - 1));
  assign w_lastRow = (r_orow == ROW_W'(OUT_H - 1));
  assign w_lastCh  = (r_ch == CH_W'(CH - 1));
  assign w_lastPix = w_lastCol && w_lastRow && w_lastCh;
  assign w_pixMax  = (up_read_data > r_max) ? up_read_data : r_max;

  always_comb begin
    w_ocolNext = w_lastCol ? '0 : r_ocol + 1'b1;
    w_orowNext = r_orow;
    w_chNext   = r_ch;
    if (w_lastCol) begin
      w_orowNext = w_lastRow ? '0 : r_orow + 1'b1;
      if (w_lastRow) w_chNext = w_lastCh ? '0 : r_ch + 1'b1;
    end
  end

  // ocol 0 lives in the most significant nibble of the row word
  always_comb begin
    w_packed = r_pack;
    for (int k = 0; k < OUT_W; k++)
      if (r_ocol == COL_W'(k)) w_packed[(OUT_W-1-k)*4 +: 4] = w_pixMax;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start && !r_done) w_next = START_UP;
      START_UP: w_next = WAIT_UP;
      WAIT_UP:  if (up_done) w_next = RD0;
      RD0:      w_next = RD1;
      RD1:      w_next = RD2;
      RD2:      w_next = RD3;
      RD3:      w_next = CMP;
      CMP:      w_next = w_lastPix ? DONE_ST : RD0;
      DONE_ST:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Each RDx state loads the address of the sample to be captured two states later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch      <= '0;
      r_orow    <= '0;
      r_ocol    <= '0;
      r_pack    <= '0;
      r_max     <= '0;
      r_upAddr  <= '0;
      r_upStart <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_upStart <= (w_next == START_UP);
      r_done    <= (r_state == DONE_ST);
      case (r_state)
        WAIT_UP: begin
          if (up_done) begin
            r_ch     <= '0;
            r_orow   <= '0;
            r_ocol   <= '0;
            r_pack   <= '0;
            r_upAddr <= '0;
          end
        end
        RD0: r_upAddr <= pixAddr(r_ch, r_orow, r_ocol, 1'b0, 1'b1);
        RD1: begin
          r_max    <= up_read_data;
          r_upAddr <= pixAddr(r_ch, r_orow, r_ocol, 1'b1, 1'b0);
        end
        RD2: begin
          r_max    <= w_pixMax;
          r_upAddr <= pixAddr(r_ch, r_orow, r_ocol, 1'b1, 1'b1);
        end
        RD3: r_max <= w_pixMax;
        CMP: begin
          r_pack   <= w_lastCol ? '0 : w_packed;
          r_ch     <= w_chNext;
          r_orow   <= w_orowNext;
          r_ocol   <= w_ocolNext;
          r_upAddr <= pixAddr(w_chNext, w_orowNext, w_ocolNext, 1'b0, 1'b0);
        end
        default: ;
      endcase
    end
  end

  assign w_wrEn  = (r_state == CMP) && w_lastCol;
  assign w_wrIdx = WORD_W'(32'(r_ch) * 32'(OUT_H) + 32'(r_orow));

  // Buffer is deliberately not reset so results survive an aborted pass
  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[w_wrIdx] <= w_packed;
  end

  // Consumer address is word*OUT_W + ocol, which slices cleanly for power-of-two OUT_W
  assign w_rdCol          = read_addr[COL_W-1:0];
  assign w_rdWord         = read_addr[COL_W +: WORD_W];
  assign w_unusedAddrBits = ^read_addr[31:COL_W+WORD_W];
  assign w_rdWordData     = r_mem[w_rdWord];

  always_comb begin
    w_rdNib = '0;
    for (int k = 0; k < OUT_W; k++)
      if (w_rdCol == COL_W'(k)) w_rdNib = w_rdWordData[(OUT_W-1-k)*4 +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_readData <= '0;
    else       r_readData <= w_rdNib;
  end

  assign up_start     = r_upStart;
  assign up_read_addr = r_upAddr;
  assign read_data    = r_readData;
  assign done         = r_done;

endmodule

// File: doc/maxpool2d_2x2_stride2_16_to_8_64ch.md
MAXPOOL2D_2X2_STRIDE2_16_TO_8_64CH -- requirements
Module: maxpool2d_2x2_stride2_16_to_8_64ch

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- IN_W, 16, input feature-map width
- IN_H, 16, input feature-map height
- CH, 64, channel count
- OUT_W, 8, output width (IN_W/2)
- OUT_H, 8, output height (IN_H/2)

REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous active-high reset
- start, in, 1, single-cycle request to run one pooling pass
- up_start, out, 1, single-cycle start pulse to the upstream conv stage
- up_done, in, 1, upstream finished; sampled only while waiting
- up_read_addr, out, 32, upstream nibble address: ch*256 + row*16 + col
- up_read_data, in, 4, upstream nibble; valid the cycle after up_read_addr is registered
- read_addr, in, 32, consumer nibble address: ch*64 + orow*8 + ocol
- read_data, out, 4, consumer nibble; registered, valid the cycle after read_addr is sampled
- done, out, 1, single-cycle completion pulse

Function
REQ-004 The internal buffer SHALL hold 512 words of 32 bits, with one word per output row at word index ch*8 + orow.
- Nibble ocol occupies bits [31-4*ocol : 28-4*ocol], so ocol 0 is in [31:28].

REQ-005 The FSM SHALL use the states IDLE, START_UP, WAIT_UP, RD0, RD1, RD2, RD3, CMP and DONE_ST.

REQ-006 In IDLE, start=1 SHALL move the FSM to START_UP; start in any other state SHALL be ignored.

REQ-007 In START_UP, the block SHALL drive up_start=1 for exactly one cycle, then move to WAIT_UP.

REQ-008 In WAIT_UP, the block SHALL hold until up_done=1.
- It SHALL then clear ch, orow, ocol and the pack register, and enter RD0.

REQ-009 The block SHALL process one output pixel (ch, orow, ocol) in exactly 5 cycles, with r = 2*orow and c = 2*ocol:
- RD0: present (r, c)
- RD1: capture and present (r, c+1)
- RD2: capture and present (r+1, c)
- RD3: capture and present (r+1, c+1)
- CMP: capture the last value and compute the result

REQ-010 The pooled value SHALL be the unsigned 4-bit maximum of the four samples; ties are irrelevant and there is no rounding or saturation.

REQ-011 In CMP, the block SHALL place the maximum into the pack-register nibble selected by ocol.
- When ocol=7, it SHALL write the completed word (including this nibble) to buffer word ch*8+orow in the same cycle.
- It SHALL then clear the pack register.

REQ-012 Counter order SHALL be ocol fastest, then orow, then ch.
- After CMP of (CH-1, 7, 7), the FSM SHALL go to DONE_ST; otherwise it SHALL return to RD0.

REQ-013 Total processing SHALL be 4096 pixels x 5 cycles = 20480 cycles.
- done SHALL be high for exactly the one cycle following the 20481st rising edge after the edge that sampled up_done=1.
- The FSM SHALL then return to IDLE.

REQ-014 The consumer read port SHALL be independent of the FSM.
- It SHALL be readable in every state.
- During a pass, it SHALL return whatever the buffer currently holds.

REQ-015 A start arriving in the same cycle as done SHALL be ignored; a start one cycle later SHALL be accepted.

REQ-016 Reads and writes to the same word in the same cycle SHALL return the old data.

Reset
REQ-017 While reset=1, the block SHALL force state=IDLE, up_start=0, done=0, up_read_addr=0, read_data=0, all counters=0 and pack register=0.
- Buffer contents SHALL NOT be cleared.

REQ-018 Reset asserted mid-pass SHALL abort immediately.
- No further buffer writes SHALL occur.
- done SHALL NOT pulse for the aborted pass.

REQ-019 After reset deasserts, the block SHALL require a new start before it does anything.

Verification
REQ-020 Basic pass: upstream model holds nibble = (ch+row+col)%7; start, up_done after 10 cycles -> exactly one up_start pulse.
- done pulses 20481 edges after up_done.
- read_addr 0 returns 2.
- read_addr 64*63+63 returns (63+15+15)%7=2.

REQ-021 Max position: each 2x2 window is all 0 except one cell = 6, with the position rotating per window -> every output nibble reads 6.

REQ-022 Packing: ch 5, orow 3 has ocol values 0..6,1 -> buffer word 43 = 32'h01234561.

REQ-023 Abort: reset asserted at pixel 1000 and released, then a new start -> no done before restart.
- The second pass completes normally with correct data.

REQ-024 Busy start: extra start pulses during WAIT_UP and CMP -> only one up_start and one done pulse.

REQ-025 Read latency: change read_addr every cycle during IDLE -> read_data matches the previously sampled address each cycle.
